pmem_line_responder: RTL and testbench
======================================

PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to pmem_resp; legal range 2..15.
REQ-002 Parameter DEPTH, default 16, number of 128-bit lines stored; power of two.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pmem_read  input  1  line read request, held until pmem_resp.
REQ-006 pmem_write  input  1  line write request, held until pmem_resp.
REQ-007 pmem_address  input  lc3b_word (16)  byte address; bits [3:0] ignored, line index = bits [4+log2(DEPTH)-1:4].
REQ-008 pmem_wdata  input  lc3b_l2_line (128)  write line.
REQ-009 pmem_rdata  output  lc3b_l2_line (128)  read line, registered.
REQ-010 pmem_resp  output  1  one-cycle completion pulse.
REQ-011 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-012 FSM states IDLE, BUSY, RESP; IDLE->BUSY when pmem_read|pmem_write sampled high in IDLE; BUSY->RESP when latency counter reaches 0; RESP->IDLE unconditionally.
REQ-013 On acceptance, the block latches address, wdata and op; write wins if read and write are both high, and proto_err is set.
REQ-014 Latency counter loads LATENCY-2 at acceptance and decrements in BUSY; pmem_resp is high exactly LATENCY cycles after the accepting edge.
REQ-015 pmem_resp high only in RESP, for exactly one cycle per accepted request.
REQ-016 Write commits latched wdata to the latched line index on the BUSY->RESP edge; pmem_rdata unchanged by writes.
REQ-017 Read loads pmem_rdata on the BUSY->RESP edge from the latched index; pmem_rdata holds the value until the next read completes.
REQ-018 Request deasserted or address/wdata/op changed while in BUSY sets proto_err; the transaction completes with latched values.
REQ-019 IDLE after RESP samples requests normally; a request still high in IDLE is a new transaction (back-to-back, minimum 1 idle cycle between pulses).
REQ-020 Address aliasing: addresses differing only above the index field map to the same line.
REQ-021 proto_err clears only on rst.

Reset
REQ-022 rst high at an edge forces IDLE, counter 0, pmem_resp 0, pmem_rdata 0, proto_err 0, and all DEPTH lines to 0.
REQ-023 rst mid-transaction aborts it: no pmem_resp, no commit; the first accept is possible on the first edge after rst falls.
REQ-024 Clearing completes within the reset cycle (flop array); no multi-cycle init.

Structure
REQ-025 lc3b_word, lc3b_l2_line and new constant PMEM_LINE_OFFSET_BITS = 4 belong in lc3b_types; FSM state enum local to module.
REQ-026 Storage is one sub-module pmem_line_array (DEPTH x 128 flops, sync write, index read, sync clear); FSM/counter live in pmem_line_responder.

Verification
REQ-027 After rst, write 0x0040 data 128'hAAAA...AAAA, then read 0x0040 -> resp at cycle 4 after each accept, rdata = 128'hAAAA...AAAA, proto_err 0.
REQ-028 Write 0x0010 = 128'h1111...1111, write 0x0110 = 128'h2222...2222 (alias), read 0x0010 -> rdata 128'h2222...2222.
REQ-029 Back-to-back reads 0x0020, 0x0030 held across resp -> two single-cycle resp pulses 5 cycles apart (LATENCY+1), correct data each.
REQ-030 read and write both high on 0x0050, wdata 128'h5555...5555 -> treated as write, proto_err 1 and stays 1 until rst; later read returns 128'h5555...5555.
REQ-031 Write accepted to 0x0060, rst asserted 2 cycles later -> no resp, read 0x0060 after reset returns 0.
REQ-032 Address changed from 0x0070 to 0x0080 mid-BUSY on a write -> line 0x0070 updated, 0x0080 unchanged, proto_err 1.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/line types and physical-memory line geometry.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_l2_line;
    localparam int PMEM_LINE_OFFSET_BITS = 4;
endpackage

// File: rtl/pmem_line_responder_if.sv
// pmem_line_responder_if: line-granular physical-memory request/response bus.
interface pmem_line_responder_if;
    import lc3b_types::*;
    logic        pmem_read;
    logic        pmem_write;
    lc3b_word    pmem_address;
    lc3b_l2_line pmem_wdata;
    lc3b_l2_line pmem_rdata;
    logic        pmem_resp;
    logic        proto_err;
    modport master (output pmem_read, pmem_write, pmem_address, pmem_wdata,
                    input pmem_rdata, pmem_resp, proto_err);
    modport slave  (input pmem_read, pmem_write, pmem_address, pmem_wdata,
                    output pmem_rdata, pmem_resp, proto_err);
endinterface

// File: rtl/pmem_line_array.sv
// pmem_line_array: DEPTH x 128-bit flop storage, sync write, index read, single-cycle clear.
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int DEPTH = 16,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  lc3b_l2_line   wdata_i,
    input  logic [IW-1:0] ridx_i,
    output lc3b_l2_line   rdata_o
);
    lc3b_l2_line mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else if (we_i) mem_q[widx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency line memory model with protocol checking.
module pmem_line_responder
    import lc3b_types::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 16
) (
    input logic                  clk,
    input logic                  rst,
    pmem_line_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    lc3b_word    addr_q, addr_d;
    lc3b_l2_line wdata_q, wdata_d, rdata_q, rdata_d, line;
    logic        we_q, we_d, err_q, err_d;
    logic        req, commit;
    logic [IW-1:0] idx;

    assign req    = bus.pmem_read | bus.pmem_write;
    assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
    assign idx    = addr_q[PMEM_LINE_OFFSET_BITS +: IW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY - 2);
                addr_d  = bus.pmem_address;
                wdata_d = bus.pmem_wdata;
                we_d    = bus.pmem_write;
                err_d   = err_q | (bus.pmem_read & bus.pmem_write);
            end
            BUSY: begin
                // master must hold a stable request until it sees pmem_resp
                err_d   = err_q | !req | (bus.pmem_address != addr_q)
                        | (bus.pmem_wdata != wdata_q) | (bus.pmem_write != we_q);
                cnt_d   = commit ? cnt_q : cnt_q - 4'd1;
                state_d = commit ? RESP : BUSY;
                rdata_d = (commit && !we_q) ? line : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    pmem_line_array #(.DEPTH(DEPTH)) u_array (
        .clk    (clk),
        .rst    (rst),
        .we_i   (commit & we_q),
        .widx_i (idx),
        .wdata_i(wdata_q),
        .ridx_i (idx),
        .rdata_o(line)
    );

    assign bus.pmem_resp  = (state_q == RESP);
    assign bus.pmem_rdata = rdata_q;
    assign bus.proto_err  = err_q;
endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder: table-driven transactions with a read-data scoreboard.
module tb_pmem_line_responder;
    import lc3b_types::*;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pmem_line_responder_if bus();
    pmem_line_responder #(.LATENCY(LAT), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        rd;
        logic        wr;
        lc3b_word    a;
        lc3b_l2_line wd;
        lc3b_l2_line er;
        logic        ee;
    } vec_t;

    vec_t        tbl [11];
    lc3b_l2_line sb [$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input lc3b_l2_line act, input lc3b_l2_line exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_resp && n < 50);
    endtask

    task automatic on_resp(input string nm, input logic is_rd);
        lc3b_l2_line e;
        if (bus.pmem_resp && is_rd) begin
            if (sb.size() == 0) chk({nm, "_sb_empty"}, 128'd1, 128'd0);
            else begin
                e = sb.pop_front();
                chk({nm, "_rdata"}, bus.pmem_rdata, e);
            end
        end
    endtask

    task automatic txn(input string nm, input vec_t v);
        int n;
        @(negedge clk);
        bus.pmem_read    = v.rd;
        bus.pmem_write   = v.wr;
        bus.pmem_address = v.a;
        bus.pmem_wdata   = v.wd;
        if (v.rd && !v.wr) sb.push_back(v.er);
        wait_resp(n);
        chk({nm, "_lat"}, 128'(n), 128'(LAT));
        on_resp(nm, v.rd && !v.wr);
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        chk({nm, "_err"}, 128'(bus.proto_err), 128'(v.ee));
    endtask

    initial begin
        int n, cnt;
        lc3b_l2_line ln_a, ln_1, ln_2, ln_3, ln_4, ln_5, ln_7;
        ln_a = {32{4'hA}}; ln_1 = {32{4'h1}}; ln_2 = {32{4'h2}}; ln_3 = {32{4'h3}};
        ln_4 = {32{4'h4}}; ln_5 = {32{4'h5}}; ln_7 = {32{4'h7}};
        tbl[0]  = '{1'b0, 1'b1, 16'h0040, ln_a, 128'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0040, 128'd0, ln_a, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0010, ln_1, 128'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0110, ln_2, 128'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0010, 128'd0, ln_2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'h0020, ln_3, 128'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 16'h0030, ln_4, 128'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0050, 128'd0, 128'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'h0050, ln_5, 128'd0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 16'h0050, 128'd0, ln_5, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'h0110, 128'd0, ln_2, 1'b1};

        bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
        bus.pmem_address = '0; bus.pmem_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_resp", 128'(bus.pmem_resp), 128'd0);
        chk("reset_rdata", bus.pmem_rdata, 128'd0);
        chk("reset_err", 128'(bus.proto_err), 128'd0);

        for (int i = 0; i < 11; i++) txn($sformatf("vec%0d", i), tbl[i]);

        // back-to-back reads: request held across the first pulse, address swapped
        @(negedge clk);
        bus.pmem_read = 1'b1; bus.pmem_address = 16'h0020; bus.pmem_wdata = '0;
        sb.push_back(ln_3);
        sb.push_back(ln_4);
        wait_resp(n);
        chk("b2b_lat0", 128'(n), 128'(LAT));
        on_resp("b2b0", 1'b1);
        bus.pmem_address = 16'h0030;
        @(negedge clk);
        chk("b2b_pulse_width", 128'(bus.pmem_resp), 128'd0);
        wait_resp(n);
        chk("b2b_gap", 128'(n + 1), 128'(LAT + 1));
        on_resp("b2b1", 1'b1);
        bus.pmem_read = 1'b0;
        chk("err_sticky", 128'(bus.proto_err), 128'd1);

        // reset two cycles into a write aborts it with no pulse and no commit
        @(negedge clk);
        bus.pmem_write = 1'b1; bus.pmem_address = 16'h0060; bus.pmem_wdata = {32{4'h6}};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.pmem_write = 1'b0;
        chk("rst_err_clr", 128'(bus.proto_err), 128'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.pmem_resp) cnt++;
            @(negedge clk);
        end
        chk("rst_no_resp", 128'(cnt), 128'd0);
        txn("rd60", '{1'b1, 1'b0, 16'h0060, 128'd0, 128'd0, 1'b0});
        txn("rd40_cleared", '{1'b1, 1'b0, 16'h0040, 128'd0, 128'd0, 1'b0});

        // address moves from 0x70 to 0x80 while BUSY: latched address wins
        @(negedge clk);
        bus.pmem_write = 1'b1; bus.pmem_address = 16'h0070; bus.pmem_wdata = ln_7;
        repeat (2) @(negedge clk);
        bus.pmem_address = 16'h0080;
        wait_resp(n);
        chk("mid_lat", 128'(n + 2), 128'(LAT));
        bus.pmem_write = 1'b0;
        chk("mid_err", 128'(bus.proto_err), 128'd1);
        txn("rd70", '{1'b1, 1'b0, 16'h0070, 128'd0, ln_7, 1'b1});
        txn("rd80", '{1'b1, 1'b0, 16'h0080, 128'd0, 128'd0, 1'b1});
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
